// File: rtl/key_debounce.sv
// Two-channel push-button debouncer for active-low keys. Each key gets a
// 2-flop synchroniser and a four-state filter that emits a clean level plus press/release pulses.

module key_debounce_ch #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic out,
    output logic press,
    output logic rls
);
    typedef enum logic [1:0] {UP, P_FILT, DOWN, R_FILT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    state_t           state;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            state <= UP;
            cnt   <= '0;
            out   <= 1'b1;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            s1    <= key;
            s2    <= s1;
            press <= 1'b0;
            rls   <= 1'b0;
            case (state)
                UP: begin
                    if (!s2) begin
                        state <= P_FILT;
                        cnt   <= '0;
                    end
                end
                P_FILT: begin
                    // Any return to released restarts the window from zero.
                    if (s2) begin
                        state <= UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DOWN;
                        cnt   <= '0;
                        out   <= 1'b0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (s2) begin
                        state <= R_FILT;
                        cnt   <= '0;
                    end
                end
                R_FILT: begin
                    if (!s2) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= UP;
                        cnt   <= '0;
                        out   <= 1'b1;
                        rls   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= UP;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

module key_debounce #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key1,
    input  logic key2,
    output logic key1_out,
    output logic key2_out,
    output logic key1_press,
    output logic key2_press,
    output logic key1_release,
    output logic key2_release
);
    localparam int NUM_KEYS = 2;

    logic [NUM_KEYS-1:0] keys, outs, press, rls;

    assign keys = {key2, key1};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX(CNT_MAX),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .key  (keys[i]),
            .out  (outs[i]),
            .press(press[i]),
            .rls  (rls[i])
        );
    end

    assign key1_out     = outs[0];
    assign key2_out     = outs[1];
    assign key1_press   = press[0];
    assign key2_press   = press[1];
    assign key1_release = rls[0];
    assign key2_release = rls[1];
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity, all checked
// against a run-length model (output flips once the synchronised key has disagreed with it for CNT_MAX+1 cycles).

module tb_key_debounce;
    localparam int CNT_MAX = 10;
    localparam int CNT_W   = 4;
    localparam int LAT     = CNT_MAX + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key1 = 1'b1, key2 = 1'b1;
    logic key1_out, key2_out, key1_press, key2_press, key1_release, key2_release;

    int checks = 0;
    int errors = 0;

    key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .key1(key1), .key2(key2),
        .key1_out(key1_out), .key2_out(key2_out),
        .key1_press(key1_press), .key2_press(key2_press),
        .key1_release(key1_release), .key2_release(key2_release)
    );

    always #10 clk = ~clk;

    // Reference model: two-sample delay line, then a count of consecutive
    // disagreeing samples per channel.
    logic d1 [2];
    logic d2 [2];
    logic mout [2];
    logic mpress [2];
    logic mrel [2];
    int   run [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            d1[c] = 1'b1; d2[c] = 1'b1; mout[c] = 1'b1;
            mpress[c] = 1'b0; mrel[c] = 1'b0; run[c] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic seen;
                seen = d2[c];
                mpress[c] = 1'b0;
                mrel[c] = 1'b0;
                if (seen != mout[c]) run[c]++;
                else run[c] = 0;
                if (run[c] == CNT_MAX + 1) begin
                    mout[c] = seen;
                    mpress[c] = !seen;
                    mrel[c] = seen;
                    run[c] = 0;
                end
                d2[c] = d1[c];
                d1[c] = (c == 0) ? key1 : key2;
            end
        end
        #1;
    endtask

    function automatic logic [5:0] obs();
        return {key2_release, key2_press, key2_out, key1_release, key1_press, key1_out};
    endfunction

    function automatic logic [5:0] expv();
        return {mrel[1], mpress[1], mout[1], mrel[0], mpress[0], mout[0]};
    endfunction

    task automatic test_reset();
        int p1, p2;
        p1 = 0; p2 = 0;
        rst = 1'b1; key1 = 1'b0; key2 = 1'b0;
        model_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (obs() !== 6'b001_001) begin
                errors++; $display("FAIL reset_hold cyc %0d got %b want %b", i, obs(), 6'b001_001);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL reset_rel cyc %0d got %b want %b", i, obs(), expv());
            end
            if (key1_press) p1 = (p1 == 0) ? i : -1;
            if (key2_press) p2 = (p2 == 0) ? i : -1;
        end
        checks++;
        if (p1 !== LAT || p2 !== LAT || key1_out !== 1'b0 || key2_out !== 1'b0) begin
            errors++; $display("FAIL reset_press edge1 %0d edge2 %0d outs %b%b want %0d 00", p1, p2, key1_out, key2_out, LAT);
        end
        key1 = 1'b1; key2 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL reset_settle cyc %0d got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_clean();
        int pe, re, np, nr;
        pe = 0; re = 0; np = 0; nr = 0;
        for (int i = 1; i <= 70; i++) begin
            key1 = (i <= 30) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL clean cyc %0d got %b want %b", i, obs(), expv());
            end
            if (key1_press) begin np++; pe = i; end
            if (key1_release) begin nr++; re = i; end
        end
        checks++;
        if (np != 1 || nr != 1 || pe != LAT || re != 30 + LAT) begin
            errors++; $display("FAIL clean_edges press %0d@%0d release %0d@%0d want 1@%0d 1@%0d", np, pe, nr, re, LAT, 30 + LAT);
        end
    endtask

    task automatic test_bounce();
        int pe, np, nr;
        pe = 0; np = 0; nr = 0;
        for (int i = 1; i <= 110; i++) begin
            if (i <= 35) key1 = (((i - 1) % 7) < 4) ? 1'b0 : 1'b1;
            else key1 = (i <= 80) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL bounce cyc %0d got %b want %b", i, obs(), expv());
            end
            if (i < 35 + LAT && (key1_out !== 1'b1 || key1_press !== 1'b0)) begin
                errors++; $display("FAIL bounce_leak cyc %0d out %b press %b want 1 0", i, key1_out, key1_press);
            end
            if (key1_press) begin np++; pe = i; end
            if (key1_release) nr++;
        end
        checks++;
        if (np != 1 || pe != 35 + LAT || nr != 1) begin
            errors++; $display("FAIL bounce_press count %0d edge %0d rel %0d want 1 %0d 1", np, pe, nr, 35 + LAT);
        end
    endtask

    task automatic test_window();
        int lens [3];
        lens[0] = CNT_MAX + 1; lens[1] = CNT_MAX; lens[2] = CNT_MAX - 1;
        for (int k = 0; k < 3; k++) begin
            int np, nr, pe, want;
            np = 0; nr = 0; pe = 0;
            want = (lens[k] >= CNT_MAX + 1) ? 1 : 0;
            for (int i = 1; i <= 45; i++) begin
                key2 = (i <= lens[k]) ? 1'b0 : 1'b1;
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL window len %0d cyc %0d got %b want %b", lens[k], i, obs(), expv());
                end
                if (key2_press) begin np++; pe = i; end
                if (key2_release) nr++;
            end
            checks++;
            if (np != want || nr != want || (want == 1 && pe != LAT)) begin
                errors++; $display("FAIL window_count len %0d press %0d@%0d rel %0d want %0d", lens[k], np, pe, nr, want);
            end
        end
    endtask

    task automatic test_simultaneous();
        int p1, p2, both;
        p1 = 0; p2 = 0; both = 0;
        for (int i = 1; i <= 60; i++) begin
            key1 = (i <= 30) ? 1'b0 : 1'b1;
            key2 = key1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL simul cyc %0d got %b want %b", i, obs(), expv());
            end
            if (key1_press) p1 = i;
            if (key2_press) p2 = i;
            if (key1_press && key2_press && !key1_out && !key2_out) both++;
        end
        checks++;
        if (p1 != LAT || p2 != LAT || both != 1) begin
            errors++; $display("FAIL simul_press edge1 %0d edge2 %0d joint %0d want %0d %0d 1", p1, p2, both, LAT, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int pe, np;
        pe = 0; np = 0;
        key1 = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            if (i == 10) rst = 1'b1;
            if (i == 12) rst = 1'b0;
            if (i == 41) key1 = 1'b1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL rstmid cyc %0d got %b want %b", i, obs(), expv());
            end
            if (key1_press) begin np++; pe = i; end
        end
        // rst drops between edges 11 and 12, so edge 12 is the first after it
        checks++;
        if (np != 1 || pe != 11 + LAT) begin
            errors++; $display("FAIL rstmid_press count %0d edge %0d want 1 %0d", np, pe, 11 + LAT);
        end
    endtask

    task automatic test_random();
        int h1, h2;
        h1 = 0; h2 = 0;
        for (int i = 1; i <= 800; i++) begin
            if (h1 == 0) begin key1 = 1'($urandom_range(0, 1)); h1 = $urandom_range(1, 16); end
            if (h2 == 0) begin key2 = 1'($urandom_range(0, 1)); h2 = $urandom_range(1, 16); end
            h1--; h2--;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random cyc %0d got %b want %b", i, obs(), expv());
            end
        end
        key1 = 1'b1; key2 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random_settle cyc %0d got %b want %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bounce();
        test_window();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
